// File: rtl/board_editor.sv
// board_editor: turns cursor clicks into read-modify-write cell toggles and
// schedules generation steps from the speed code, never overlapping the two.
// Optional single-step button input: define BOARD_EDITOR_SINGLE_STEP_EN.
module board_editor #(
    parameter int LOG_BOARD_SIZE = 8,
    parameter int LOG_MAX_SPEED  = 4,
    parameter int LOG_TICK_BASE  = 24,
    parameter int READ_LATENCY   = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        click_in,
`ifdef BOARD_EDITOR_SINGLE_STEP_EN
    input  logic                        step_btn_in,
`endif
    input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
    input  logic [LOG_MAX_SPEED-1:0]    speed_in,
    input  logic                        engine_busy_in,
    input  logic                        mem_gnt_in,
    input  logic                        mem_rdata_in,
    output logic                        mem_req_out,
    output logic                        mem_we_out,
    output logic [2*LOG_BOARD_SIZE-1:0] mem_addr_out,
    output logic                        mem_wdata_out,
    output logic                        step_out,
    output logic                        edit_busy_out
);
    localparam int WW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t                   state, state_d;
    logic                     click_q, edit_pend, step_pend;
    logic                     click_take, tick, step_req;
    logic [LOG_MAX_SPEED-1:0] speed_q, shift_amt;
    logic [LOG_TICK_BASE-1:0] count, limit;
    logic [WW-1:0]            wait_cnt;

    // A click is only accepted when no edit is pending or in flight.
    assign click_take    = click_in && !click_q && !edit_pend && state == IDLE;
    assign shift_amt     = speed_in - LOG_MAX_SPEED'(1);
    assign limit         = {LOG_TICK_BASE{1'b1}} >> shift_amt;
    assign tick          = speed_in != '0 && speed_in == speed_q && count == limit;
    assign edit_busy_out = edit_pend || state != IDLE;

`ifdef BOARD_EDITOR_SINGLE_STEP_EN
    logic btn_q;

    // Step button edge history; a button held through reset does not step.
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) btn_q <= step_btn_in;
        else btn_q <= step_btn_in;

    assign step_req = tick || (step_btn_in && !btn_q && speed_in == '0);
`else
    assign step_req = tick;
`endif

    // Click edge detection, cursor latch and edit-pending flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            click_q      <= click_in;
            edit_pend    <= 1'b0;
            mem_addr_out <= '0;
        end else begin
            click_q <= click_in;
            if (click_take) begin
                edit_pend    <= 1'b1;
                mem_addr_out <= {cursor_y_in, cursor_x_in};
            end else if (state == RD_REQ && mem_gnt_in) begin
                edit_pend <= 1'b0;
            end
        end
    end

    // Step prescaler; a fresh tick wins over the clear from an issued step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            speed_q   <= '0;
            count     <= '0;
            step_pend <= 1'b0;
        end else begin
            speed_q   <= speed_in;
            count     <= (speed_in == '0 || speed_in != speed_q || count == limit) ?
                         '0 : count + LOG_TICK_BASE'(1);
            step_pend <= step_req || (step_pend && !step_out);
        end
    end

    // FSM state, read-latency countdown and toggled write data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            mem_wdata_out <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= state == RD_REQ  ? WW'(READ_LATENCY - 1) :
                        state == RD_WAIT ? wait_cnt - WW'(1) : wait_cnt;
            if (state == RD_WAIT && wait_cnt == '0)
                mem_wdata_out <= ~mem_rdata_in;
        end
    end

    // Next state and request/step outputs; edits take priority over steps.
    always_comb begin
        state_d     = state;
        mem_req_out = 1'b0;
        mem_we_out  = 1'b0;
        step_out    = 1'b0;
        case (state)
            IDLE: begin
                if (edit_pend && !engine_busy_in) state_d = RD_REQ;
                step_out = step_pend && !edit_pend && !engine_busy_in;
            end
            RD_REQ: begin
                mem_req_out = 1'b1;
                if (mem_gnt_in) state_d = RD_WAIT;
            end
            RD_WAIT: if (wait_cnt == '0) state_d = WR_REQ;
            WR_REQ: begin
                mem_req_out = 1'b1;
                mem_we_out  = 1'b1;
                if (mem_gnt_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_board_editor.sv
// tb_board_editor: directed checks of click editing, step prescaler and reset
module tb_board_editor;
    logic        clk_in = 1'b0, rst_in = 1'b1, click_in = 1'b1;
    logic [7:0]  cursor_x_in = '0, cursor_y_in = '0;
    logic [3:0]  speed_in = '0;
    logic        engine_busy_in = 1'b0, mem_gnt_in = 1'b1, mem_rdata_in = 1'b0;
    logic        mem_req_out, mem_we_out, mem_wdata_out, step_out, edit_busy_out;
    logic [15:0] mem_addr_out;
`ifdef BOARD_EDITOR_SINGLE_STEP_EN
    logic        step_btn_in = 1'b0;
`endif
    int n_chk = 0, n_fail = 0;
    int rd_cnt = 0, wr_cnt = 0, steps = 0, s0 = 0, w0 = 0;

    board_editor #(.LOG_BOARD_SIZE(8), .LOG_MAX_SPEED(4), .LOG_TICK_BASE(4), .READ_LATENCY(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .click_in(click_in),
`ifdef BOARD_EDITOR_SINGLE_STEP_EN
        .step_btn_in(step_btn_in),
`endif
        .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in), .speed_in(speed_in),
        .engine_busy_in(engine_busy_in), .mem_gnt_in(mem_gnt_in), .mem_rdata_in(mem_rdata_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .step_out(step_out), .edit_busy_out(edit_busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Count granted reads/writes and issued steps at each active edge.
    always @(posedge clk_in) begin
        if (mem_req_out && mem_gnt_in && !mem_we_out) rd_cnt++;
        if (mem_req_out && mem_gnt_in && mem_we_out) wr_cnt++;
        if (step_out) steps++;
    end

    task automatic nx();
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset with click held
        nx(); nx();
        chk("rst_req", mem_req_out, 0);
        chk("rst_step", step_out, 0);
        chk("rst_busy", edit_busy_out, 0);
        chk("rst_addr", mem_addr_out, 0);
        chk("rst_wdata", mem_wdata_out, 0);
        rst_in = 1'b0;
        repeat (4) nx();
        chk("held_busy", edit_busy_out, 0);
        chk("held_rd", rd_cnt, 0);
        // edit at cursor (3,5), immediate grants, read data 0
        click_in = 1'b0; cursor_x_in = 8'd3; cursor_y_in = 8'd5;
        nx();
        click_in = 1'b1;
        nx();
        chk("e1_c1_busy", edit_busy_out, 1);
        chk("e1_c1_req", mem_req_out, 0);
        click_in = 1'b0;
        nx();
        chk("e1_c2_req", mem_req_out, 1);
        chk("e1_c2_we", mem_we_out, 0);
        chk("e1_c2_addr", mem_addr_out, 16'h0503);
        chk("e1_c2_busy", edit_busy_out, 1);
        click_in = 1'b1;
        nx();
        chk("e1_c3_req", mem_req_out, 0);
        chk("e1_c3_busy", edit_busy_out, 1);
        nx();
        chk("e1_c4_req", mem_req_out, 0);
        chk("e1_c4_busy", edit_busy_out, 1);
        nx();
        chk("e1_c5_req", mem_req_out, 1);
        chk("e1_c5_we", mem_we_out, 1);
        chk("e1_c5_addr", mem_addr_out, 16'h0503);
        chk("e1_c5_wdata", mem_wdata_out, 1);
        chk("e1_c5_busy", edit_busy_out, 1);
        nx();
        chk("e1_c6_req", mem_req_out, 0);
        chk("e1_c6_busy", edit_busy_out, 0);
        chk("e1_rd", rd_cnt, 1);
        chk("e1_wr", wr_cnt, 1);
        repeat (4) nx();
        chk("drop_busy", edit_busy_out, 0);
        chk("drop_wr", wr_cnt, 1);
        // engine busy blocks the edit, then grant withheld for two cycles
        click_in = 1'b0;
        nx();
        engine_busy_in = 1'b1; click_in = 1'b1; cursor_x_in = 8'hA0; cursor_y_in = 8'h0F;
        nx();
        chk("bz_busy", edit_busy_out, 1);
        for (int i = 0; i < 20; i++) begin
            nx();
            chk("bz_req", mem_req_out, 0);
        end
        engine_busy_in = 1'b0;
        nx();
        chk("bz_d0_req", mem_req_out, 1);
        chk("bz_d0_addr", mem_addr_out, 16'h0FA0);
        mem_gnt_in = 1'b0;
        nx();
        chk("bz_d1_req", mem_req_out, 1);
        nx();
        chk("bz_d2_req", mem_req_out, 1);
        chk("bz_d2_we", mem_we_out, 0);
        chk("bz_d2_addr", mem_addr_out, 16'h0FA0);
        mem_gnt_in = 1'b1; mem_rdata_in = 1'b1;
        nx();
        chk("bz_d3_req", mem_req_out, 0);
        nx();
        chk("bz_d4_req", mem_req_out, 0);
        nx();
        chk("bz_d5_req", mem_req_out, 1);
        chk("bz_d5_we", mem_we_out, 1);
        chk("bz_d5_wdata", mem_wdata_out, 0);
        chk("bz_d5_addr", mem_addr_out, 16'h0FA0);
        nx();
        chk("bz_d6_req", mem_req_out, 0);
        chk("bz_rd", rd_cnt, 2);
        chk("bz_wr", wr_cnt, 2);
        // prescaler periods with a 4-bit tick base
        speed_in = 4'd1; repeat (3) nx(); s0 = steps;
        repeat (64) nx();
        chk("spd1_steps", steps - s0, 4);
        speed_in = 4'd4; repeat (3) nx(); s0 = steps;
        repeat (20) nx();
        chk("spd4_steps", steps - s0, 10);
        speed_in = 4'd8; repeat (3) nx(); s0 = steps;
        repeat (20) nx();
        chk("spd8_steps", steps - s0, 20);
        speed_in = 4'd0; repeat (3) nx(); s0 = steps;
        repeat (100) nx();
        chk("spd0_steps", steps - s0, 0);
        // pending click and step: edit first, step on first free IDLE cycle
        engine_busy_in = 1'b1; speed_in = 4'd8; click_in = 1'b0;
        nx();
        click_in = 1'b1; cursor_x_in = 8'h11; cursor_y_in = 8'h22;
        nx(); nx();
        s0 = steps;
        chk("pr_busy_step", step_out, 0);
        engine_busy_in = 1'b0;
        #1;
        chk("pr_e0_step", step_out, 0);
        for (int i = 0; i < 4; i++) begin
            nx();
            chk("pr_edit_step", step_out, 0);
            chk("pr_edit_busy", edit_busy_out, 1);
        end
        chk("pr_e4_addr", mem_addr_out, 16'h2211);
        chk("pr_e4_we", mem_we_out, 1);
        nx();
        chk("pr_e5_step", step_out, 1);
        chk("pr_e5_busy", edit_busy_out, 0);
        chk("pr_nostep_during", steps - s0, 0);
        chk("pr_wr", wr_cnt, 3);
        speed_in = 4'd0; repeat (3) nx(); s0 = steps;
        repeat (100) nx();
        chk("pause_steps", steps - s0, 0);
        // reset during RD_WAIT abandons the edit
        click_in = 1'b0; mem_rdata_in = 1'b0;
        nx();
        click_in = 1'b1; cursor_x_in = 8'd1; cursor_y_in = 8'd2;
        nx();
        nx();
        chk("ra_req", mem_req_out, 1);
        nx();
        chk("ra_wait_req", mem_req_out, 0);
        chk("ra_wait_busy", edit_busy_out, 1);
        rst_in = 1'b1;
        #1;
        chk("ra_rst_busy", edit_busy_out, 0);
        chk("ra_rst_addr", mem_addr_out, 0);
        chk("ra_rst_req", mem_req_out, 0);
        nx(); nx();
        rst_in = 1'b0; w0 = wr_cnt; s0 = rd_cnt;
        repeat (10) nx();
        chk("ra_no_wr", wr_cnt - w0, 0);
        chk("ra_no_rd", rd_cnt - s0, 0);
        chk("ra_idle_busy", edit_busy_out, 0);
        chk("ra_wdata", mem_wdata_out, 0);
`ifdef BOARD_EDITOR_SINGLE_STEP_EN
        // single step while paused
        s0 = steps; step_btn_in = 1'b1;
        nx();
        chk("ss_step", step_out, 1);
        nx();
        chk("ss_step_clr", step_out, 0);
        repeat (5) nx();
        chk("ss_count", steps - s0, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/board_editor.md
Name: board_editor

Overview:
- Sits directly downstream of the user-interface stage. Consumes the debounced click level, the cursor coordinates and the speed code.
- Turns a click into a read-modify-write toggle of one cell in board memory.
- Generates the generation-advance strobe (step_out) for the life engine from the speed code.
- Ensures cell edits and generation steps never overlap.

Parameters:
- LOG_BOARD_SIZE, 8, log2 of board edge. Cell address width is 2*LOG_BOARD_SIZE.
- LOG_MAX_SPEED, 4, width of the speed code.
- LOG_TICK_BASE, 24, width of the step prescaler. The slowest step period is 2**LOG_TICK_BASE cycles.
- READ_LATENCY, 2, cycles from accepted read request to valid mem_rdata_in (at least 1).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- click_in  input  1  debounced click level
- cursor_x_in  input  LOG_BOARD_SIZE  cursor column
- cursor_y_in  input  LOG_BOARD_SIZE  cursor row
- speed_in  input  LOG_MAX_SPEED  0 = paused; 1 = slowest; larger = faster
- engine_busy_in  input  1  life engine is computing a generation
- mem_gnt_in  input  1  memory accepted the current request this cycle
- mem_rdata_in  input  1  cell read data
- mem_req_out  output  1  memory request valid
- mem_we_out  output  1  1 = write, 0 = read
- mem_addr_out  output  2*LOG_BOARD_SIZE  {cursor_y, cursor_x} latched at the click
- mem_wdata_out  output  1  toggled cell value
- step_out  output  1  one-cycle pulse: advance one generation
- edit_busy_out  output  1  an edit is pending or in flight

Behaviour:
- Reset: async on rst_in high. All outputs 0. FSM goes to IDLE. Prescaler is 0. Pending flags are cleared. Click edge history takes the current click_in value, so a button held during reset does not edit.
- Reset mid-transaction abandons the edit. No write is issued after reset.
- Click capture: a rising edge of click_in latches {cursor_y_in, cursor_x_in} and sets edit_pend.
  - An edge arriving while edit_pend is set or the FSM is not IDLE is dropped.
  - edit_busy_out = edit_pend OR (state != IDLE).
- Prescaler: limit = ({LOG_TICK_BASE{1'b1}} >> (speed_in-1)).
  - Shift amounts of LOG_TICK_BASE or more give limit 0, i.e. a step every cycle.
  - The counter increments each cycle while speed_in != 0.
  - When count == limit: count returns to 0 and step_pend is set. Pending steps saturate at one.
  - speed_in == 0: count is held at 0. An existing step_pend is retained.
  - Any change of speed_in (registered compare) zeroes count in the following cycle.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE, when edit_pend and !engine_busy_in: go to RD_REQ. Edit takes priority over step.
  - IDLE, else when step_pend and !engine_busy_in: step_out = 1 for one cycle, clear step_pend, stay IDLE.
  - RD_REQ: mem_req_out = 1, mem_we_out = 0, address = latch. On mem_gnt_in, clear edit_pend and go to RD_WAIT with wait counter = READ_LATENCY-1.
  - RD_WAIT: count down. At 0, capture mem_wdata_out = ~mem_rdata_in and go to WR_REQ.
  - WR_REQ: mem_req_out = 1, mem_we_out = 1. On mem_gnt_in, go to IDLE. mem_req_out drops the next cycle.
- Request rule: mem_req_out, mem_addr_out and mem_we_out stay stable until granted.
- step_out is never asserted while state != IDLE or while engine_busy_in is high.
- Edit latency with immediate grant: 1 (IDLE) + 1 (RD_REQ) + READ_LATENCY + 1 (WR_REQ) cycles from the registered click edge.

Optional Feature:
- Macro: BOARD_EDITOR_SINGLE_STEP_EN.
- Defined:
  - Adds input step_btn_in (1 bit, debounced).
  - A rising edge while speed_in == 0 sets step_pend, so exactly one generation is issued under the normal FSM rules.
  - Edges while speed_in != 0 are ignored.
- Undefined: the port is absent, and the paused state only advances via a step_pend left over from before the pause.

Test Plan:
- Reset with click_in held at 1, then release and press again: no memory activity after reset. The second press produces exactly one read then one write at the latched address.
- LOG_TICK_BASE = 4, speed_in = 1: step_out pulses every 16 cycles. speed_in = 4: every 2 cycles. speed_in = 8: every cycle. speed_in = 0: no pulses over 100 cycles.
- Cursor (3, 5), click, mem_rdata_in = 0, grants immediate, READ_LATENCY = 2: write addr = {5, 3}, wdata = 1. Total 5 cycles; edit_busy_out is high throughout.
- Click and step become pending in the same cycle with engine_busy_in = 0: the edit completes first, then step_out pulses on the first IDLE cycle after WR_REQ is granted.
- engine_busy_in held high for 20 cycles with a click pending: mem_req_out stays 0. The read starts the cycle after busy drops.
- rst_in asserted during RD_WAIT: outputs go to 0 immediately and no write follows. A second click during an active edit is dropped: only one write occurs.
